vga_timing_gen: RTL and testbench

- Raster timing generator for the VGA game path; sits directly upstream of the block image/pixel stage.
- Produces the horizontal and vertical position counters (hst, vst), the hsync/vsync pulses, an active-video flag and line/frame strobes.
- The pixel stage consumes these to generate rgb.
- Default timing is 800x600@72 Hz on a 50 MHz pixel clock: one pixel per enabled clk cycle.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_axis_cnt.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster timing generator.
// Default values describe 800x600@72 Hz on a 50 MHz pixel clock.
package vga_timing_pkg;

    localparam int HST_W = 11;
    localparam int VST_W = 10;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FP_DEF      = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BP_DEF      = 64;
    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FP_DEF      = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BP_DEF      = 23;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
    } sync_win_t;

    // Sync window is [lo, hi): it starts right after the front porch.
    function automatic sync_win_t sync_window(input int visible, input int fp, input int sync);
        sync_win_t w;
        w.lo = 16'(visible + fp);
        w.hi = 16'(visible + fp + sync);
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrap counter with step enable, wrap flag and sync/active decode.
// Sync is registered from the next count so it always matches the presented position.
module vga_axis_cnt #(
    parameter int W      = 11,
    parameter int TOTAL  = 1040,
    parameter int VIS    = 800,
    parameter int WIN_LO = 856,
    parameter int WIN_HI = 976,
    parameter bit POL    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         sync,
    output logic         act_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_L = W'(VIS);
    localparam logic [W-1:0] LO_L  = W'(WIN_LO);
    localparam logic [W-1:0] HI_L  = W'(WIN_HI);

    logic [W-1:0] pos_r;
    logic [W-1:0] nxt_s;
    logic         sync_r;
    logic         sync_nxt_s;

    // Next position and its decode.
    always_comb begin
        nxt_s = pos_r;
        wrap  = 1'b0;
        if (step) begin
            if (pos_r == LAST) begin
                nxt_s = {W{1'b0}};
                wrap  = 1'b1;
            end else begin
                nxt_s = pos_r + W'(1);
            end
        end else begin
            nxt_s = pos_r;
        end
        act_nxt = (nxt_s < VIS_L);
        if ((nxt_s >= LO_L) && (nxt_s < HI_L)) begin
            sync_nxt_s = POL;
        end else begin
            sync_nxt_s = ~POL;
        end
    end

    // Position and sync registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r  <= LAST;
            sync_r <= ~POL;
        end else begin
            pos_r  <= nxt_s;
            sync_r <= sync_nxt_s;
        end
    end

    assign pos  = pos_r;
    assign sync = sync_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position counters, syncs, data-enable and strobes.
// Optional 16-bit frame counter port when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [HST_W-1:0] hst,
    output logic [VST_W-1:0] vst,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam sync_win_t H_WIN = sync_window(H_VISIBLE, H_FP, H_SYNC);
    localparam sync_win_t V_WIN = sync_window(V_VISIBLE, V_FP, V_SYNC);

    if ((H_TOTAL > 2048) || (V_TOTAL > 1024) ||
        (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_param_check
        $error("vga_timing_gen: invalid timing parameters");
    end

    logic h_wrap_s;
    logic v_wrap_s;
    logic h_act_s;
    logic v_act_s;
    logic de_r;
    logic line_start_r;
    logic frame_start_r;

    vga_axis_cnt #(
        .W(HST_W), .TOTAL(H_TOTAL), .VIS(H_VISIBLE),
        .WIN_LO(int'(H_WIN.lo)), .WIN_HI(int'(H_WIN.hi)), .POL(H_POL)
    ) u_h (
        .clk(clk), .rst(rst), .step(en),
        .pos(hst), .sync(hsync), .act_nxt(h_act_s), .wrap(h_wrap_s)
    );

    // Vertical axis advances once per horizontal wrap.
    vga_axis_cnt #(
        .W(VST_W), .TOTAL(V_TOTAL), .VIS(V_VISIBLE),
        .WIN_LO(int'(V_WIN.lo)), .WIN_HI(int'(V_WIN.hi)), .POL(V_POL)
    ) u_v (
        .clk(clk), .rst(rst), .step(h_wrap_s),
        .pos(vst), .sync(vsync), .act_nxt(v_act_s), .wrap(v_wrap_s)
    );

    // Data-enable and strobes, registered alongside the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_r          <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            de_r          <= h_act_s & v_act_s;
            line_start_r  <= h_wrap_s;
            frame_start_r <= h_wrap_s & v_wrap_s;
        end
    end

    assign de          = de_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter steps together with the frame_start strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (h_wrap_s & v_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    // No frame counter in this build.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-timing instance driven by a vector table, plus a
// small-timing instance for frame wrap, vsync window and reset-in-sync sequences.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst, en, rst_s, en_s;
    logic [10:0] hst, hst_s;
    logic [9:0]  vst, vst_s;
    logic        hsync, vsync, de, line_start, frame_start;
    logic        hsync_s, vsync_s, de_s, line_start_s, frame_start_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    always #10 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .rst(rst), .en(en), .hst(hst), .vst(vst),
        .hsync(hsync), .vsync(vsync), .de(de),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    // Small raster: 15 x 11, hsync active-low at hst 10..12, vsync at vst 8..9.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .hst(hst_s), .vst(vst_s),
        .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
        .line_start(line_start_s), .frame_start(frame_start_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int hst, vst;
        bit hsync, vsync, de, ls, fs;
        int fc;
    } obs_t;

    typedef struct {
        bit r, e;
        int n;
        int hst, vst;
        bit hs, vs, de, ls, fs;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    cfg_t c0, c1;
    obs_t m0, m1;
    obs_t q0[$];
    obs_t q1[$];
    vec_t tv[17];

    function automatic obs_t model_next(cfg_t c, obs_t s, bit r, bit e);
        obs_t n;
        int ht, vt;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        n = s;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (r) begin
            n.hst = ht - 1;  n.vst = vt - 1;
            n.hsync = ~c.hp; n.vsync = ~c.vp;
            n.de = 1'b0;     n.fc = 0;
        end else if (e) begin
            n.hst = s.hst + 1;
            if (n.hst == ht) begin
                n.hst = 0;
                n.vst = (s.vst + 1 == vt) ? 0 : s.vst + 1;
            end
            n.hsync = (n.hst >= c.hv + c.hf && n.hst < c.hv + c.hf + c.hs) ? c.hp : ~c.hp;
            n.vsync = (n.vst >= c.vv + c.vf && n.vst < c.vv + c.vf + c.vs) ? c.vp : ~c.vp;
            n.de = (n.hst < c.hv) && (n.vst < c.vv);
            n.ls = (n.hst == 0);
            n.fs = n.ls && (n.vst == 0);
            if (n.fs) n.fc = (s.fc + 1) % 65536;
        end
        return n;
    endfunction

    function automatic obs_t get0();
        obs_t o;
        o.hst = int'(hst); o.vst = int'(vst);
        o.hsync = hsync; o.vsync = vsync; o.de = de;
        o.ls = line_start; o.fs = frame_start;
        o.fc = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.fc = int'(fc0);
`endif
        return o;
    endfunction

    function automatic obs_t get1();
        obs_t o;
        o.hst = int'(hst_s); o.vst = int'(vst_s);
        o.hsync = hsync_s; o.vsync = vsync_s; o.de = de_s;
        o.ls = line_start_s; o.fs = frame_start_s;
        o.fc = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
        o.fc = int'(fc1);
`endif
        return o;
    endfunction

    task automatic cmp(input string name, input obs_t a, input obs_t x, input bit use_fc);
        bit bad;
        tests++;
        bad = (a.hst != x.hst) || (a.vst != x.vst) || (a.hsync != x.hsync) ||
              (a.vsync != x.vsync) || (a.de != x.de) || (a.ls != x.ls) || (a.fs != x.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (use_fc && (a.fc != x.fc)) bad = 1'b1;
`endif
        if (bad) begin
            fails++;
            $display("FAIL %s: got hst=%0d vst=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d, expected hst=%0d vst=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d (t=%0t)",
                     name, a.hst, a.vst, a.hsync, a.vsync, a.de, a.ls, a.fs, a.fc,
                     x.hst, x.vst, x.hsync, x.vsync, x.de, x.ls, x.fs, x.fc, $time);
        end
    endtask

    task automatic cmpi(input string name, input int a, input int x);
        tests++;
        if (a != x) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, a, x);
        end
    endtask

    // One clock for both instances; expectations queued at drive, checked after the edge.
    task automatic tick(input bit r0, input bit e0, input bit r1, input bit e1);
        @(negedge clk);
        rst = r0; en = e0; rst_s = r1; en_s = e1;
        m0 = model_next(c0, m0, r0, e0);
        m1 = model_next(c1, m1, r1, e1);
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge clk);
        #1;
        cmp("sb_default", get0(), q0.pop_front(), 1'b1);
        cmp("sb_small", get1(), q1.pop_front(), 1'b1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t x;
        int nfs, last_fs, hs_cnt, vs_cnt;
        rst = 1'b1; en = 1'b0; rst_s = 1'b1; en_s = 1'b0;
        c0 = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
        c1 = '{8, 2, 3, 2, 6, 2, 2, 1, 1'b0, 1'b1};
        m0 = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        m1 = m0;

        //            r     e     n     hst   vst  hs    vs    de    ls    fs
        tv[0]  = '{1'b1, 1'b0,    3, 1039, 665, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b1,    1,    0,   0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[2]  = '{1'b0, 1'b1,  799,  799,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1,    1,  800,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b1,   56,  856,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b1,  119,  975,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 1'b1,    1,  976,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b1,   63, 1039,   0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1,    1,    0,   1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b1,  500,  500,   1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b0,    7,  500,   1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b1,    1,  501,   1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[12] = '{1'b0, 1'b1,  538, 1039,   1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b1, 4160, 1039,   5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[14] = '{1'b0, 1'b1,    1,    0,   6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[15] = '{1'b0, 1'b1,  900,  900,   6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[16] = '{1'b1, 1'b1,    1, 1039, 665, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            for (int k = 0; k < tv[i].n; k++) tick(tv[i].r, tv[i].e, 1'b1, 1'b0);
            x = '{tv[i].hst, tv[i].vst, tv[i].hs, tv[i].vs, tv[i].de, tv[i].ls, tv[i].fs, 0};
            cmp($sformatf("tbl%0d", i), get0(), x, 1'b0);
        end

        // Small raster: walk to hst=11, vst=8 where both syncs are active.
        for (int k = 0; k < 132; k++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        x = '{11, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        cmp("small_in_sync", get1(), x, 1'b0);

        // Reset inside both sync pulses: no partial pulse survives.
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        x = '{14, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        cmp("small_rst_in_sync", get1(), x, 1'b0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        cmpi("fc_reset", int'(fc1), 0);
`endif

        // Three frames: period, sync widths and frame count.
        nfs = 0; last_fs = 0; hs_cnt = 0; vs_cnt = 0;
        for (int i = 1; i <= 495; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            if (i <= 165) begin
                if (hsync_s == 1'b0) hs_cnt++;
                if (vsync_s == 1'b1) vs_cnt++;
            end
            if (frame_start_s) begin
                nfs++;
                if (last_fs > 0) cmpi("frame_period", i - last_fs, 165);
                last_fs = i;
`ifdef VGA_TIMING_FRAME_CNT_EN
                cmpi("fc_count", int'(fc1), nfs);
`endif
            end
        end
        cmpi("frame_starts", nfs, 3);
        cmpi("hsync_cycles_per_frame", hs_cnt, 33);
        cmpi("vsync_cycles_per_frame", vs_cnt, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
